// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters, sync pulses, active-video
// flag, line/frame strobes and a completed-frame counter. All state moves
// on clk only when pix_en is high, so the block runs from the system clock.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CW       = 10,
  parameter int   FW       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  output logic [CW-1:0] h_count,
  output logic [CW-1:0] v_count,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          line_end,
  output logic          frame_end,
  output logic [FW-1:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CW1     = CW + 1;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  // Decode bounds carry one extra bit so a sync window ending exactly at
  // the total count still fits; an empty window (SYNC=0) never matches.
  localparam logic [CW1-1:0] H_VID_END = CW1'(H_ACTIVE);
  localparam logic [CW1-1:0] HS_BEG    = CW1'(H_ACTIVE + H_FP);
  localparam logic [CW1-1:0] HS_END    = CW1'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW1-1:0] V_VID_END = CW1'(V_ACTIVE);
  localparam logic [CW1-1:0] VS_BEG    = CW1'(V_ACTIVE + V_FP);
  localparam logic [CW1-1:0] VS_END    = CW1'(V_ACTIVE + V_FP + V_SYNC);

  // video_on after reset is simply the decode of position (0,0).
  localparam logic VIDEO_AT_ORIGIN = (H_ACTIVE > 0) && (V_ACTIVE > 0);

  logic          h_last;
  logic          v_last;
  logic [CW-1:0] h_next;
  logic [CW-1:0] v_next;
  logic          hs_next;
  logic          vs_next;
  logic          video_next;

  // Next position and its decode, so registered syncs line up with the counters.
  always_comb begin
    h_last = (h_count == H_LAST);
    v_last = (v_count == V_LAST);
    h_next = h_count + CW'(1);
    v_next = v_count;
    if (h_last) begin
      h_next = '0;
      v_next = v_last ? '0 : (v_count + CW'(1));
    end
    hs_next    = ({1'b0, h_next} >= HS_BEG) && ({1'b0, h_next} < HS_END);
    vs_next    = ({1'b0, v_next} >= VS_BEG) && ({1'b0, v_next} < VS_END);
    video_next = ({1'b0, h_next} < H_VID_END) && ({1'b0, v_next} < V_VID_END);
  end

  // Strobes are combinational so they fall in the last enabled cycle of a line/frame.
  always_comb begin
    line_end  = pix_en && h_last;
    frame_end = pix_en && h_last && v_last;
  end

  // Counter and sync registers; everything holds while pix_en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_count     <= '0;
      v_count     <= '0;
      frame_count <= '0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      video_on    <= VIDEO_AT_ORIGIN;
    end else if (pix_en) begin
      h_count  <= h_next;
      v_count  <= v_next;
      hsync    <= hs_next ? HS_POL : ~HS_POL;
      vsync    <= vs_next ? VS_POL : ~VS_POL;
      video_on <= video_next;
      if (h_last && v_last) frame_count <= frame_count + FW'(1);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small raster (normal and inverted polarity) plus
// the default 640x480 raster at 1-in-4 pixel enable, all compared each
// cycle against a position model derived from an enabled-tick count.
module tb_vga_timing_gen;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
    bit hp, vp;
  } cfg_t;

  typedef struct {
    int h, v, f;
    bit hs, vs, von, le, fe;
  } out_t;

  typedef struct {
    int cycles;
    bit en;
    int h, v, f;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pix_en = 1'b0;
  logic pix_en_d = 1'b0;
  bit   chk_on = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  longint t_s = 0;
  longint t_d = 0;
  cfg_t cfg_s, cfg_i, cfg_d;
  int   div = 0;

  logic [9:0] a_h, a_v, b_h, b_v, d_h, d_v;
  logic [7:0] a_f, b_f, d_f;
  logic a_hs, a_vs, a_von, a_le, a_fe;
  logic b_hs, b_vs, b_von, b_le, b_fe;
  logic d_hs, d_vs, d_von, d_le, d_fe;

  always #5 clk = ~clk;

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                   .HS_POL(1'b0), .VS_POL(1'b0), .CW(10), .FW(8)) dut_a (
    .clk(clk), .rst(rst), .pix_en(pix_en), .h_count(a_h), .v_count(a_v),
    .hsync(a_hs), .vsync(a_vs), .video_on(a_von), .line_end(a_le),
    .frame_end(a_fe), .frame_count(a_f));

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                   .HS_POL(1'b1), .VS_POL(1'b1), .CW(10), .FW(8)) dut_b (
    .clk(clk), .rst(rst), .pix_en(pix_en), .h_count(b_h), .v_count(b_v),
    .hsync(b_hs), .vsync(b_vs), .video_on(b_von), .line_end(b_le),
    .frame_end(b_fe), .frame_count(b_f));

  vga_timing_gen dut_d (
    .clk(clk), .rst(rst), .pix_en(pix_en_d), .h_count(d_h), .v_count(d_v),
    .hsync(d_hs), .vsync(d_vs), .video_on(d_von), .line_end(d_le),
    .frame_end(d_fe), .frame_count(d_f));

  // Position follows from the number of enabled ticks since reset.
  function automatic out_t model(input cfg_t c, input longint t, input bit en);
    out_t   o;
    longint ht, vt;
    ht    = c.ha + c.hf + c.hs + c.hb;
    vt    = c.va + c.vf + c.vs + c.vb;
    o.h   = int'(t % ht);
    o.v   = int'((t / ht) % vt);
    o.f   = int'((t / (ht * vt)) % 256);
    o.hs  = ((o.h >= c.ha + c.hf) && (o.h < c.ha + c.hf + c.hs)) ? c.hp : !c.hp;
    o.vs  = ((o.v >= c.va + c.vf) && (o.v < c.va + c.vf + c.vs)) ? c.vp : !c.vp;
    o.von = (o.h < c.ha) && (o.v < c.va);
    o.le  = en && (o.h == ht - 1);
    o.fe  = o.le && (o.v == vt - 1);
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_set(input string tag, input out_t e, input logic [9:0] h, v,
                         input logic [7:0] f, input logic hs, vs, von, le, fe);
    chk({tag, "_h"}, h, e.h);
    chk({tag, "_v"}, v, e.v);
    chk({tag, "_frame"}, f, e.f);
    chk({tag, "_hsync"}, hs, e.hs);
    chk({tag, "_vsync"}, vs, e.vs);
    chk({tag, "_video_on"}, von, e.von);
    chk({tag, "_line_end"}, le, e.le);
    chk({tag, "_frame_end"}, fe, e.fe);
  endtask

  task automatic step(input bit en);
    pix_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Tick counters for the reference model.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t_s <= 0;
      t_d <= 0;
    end else begin
      if (pix_en)   t_s <= t_s + 1;
      if (pix_en_d) t_d <= t_d + 1;
    end
  end

  // Every-cycle comparison of all three instances, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk_set("a", model(cfg_s, t_s, pix_en), a_h, a_v, a_f, a_hs, a_vs, a_von, a_le, a_fe);
      chk_set("b", model(cfg_i, t_s, pix_en), b_h, b_v, b_f, b_hs, b_vs, b_von, b_le, b_fe);
      chk_set("d", model(cfg_d, t_d, pix_en_d), d_h, d_v, d_f, d_hs, d_vs, d_von, d_le, d_fe);
    end
  end

  // 1-in-4 pixel enable for the default-size instance.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      div = (div + 1) % 4;
      pix_en_d = (div == 0);
    end
  end

  initial begin
    vec_t vecs[7];
    int   von_n, hs_n, vs_n, le_n, fe_n;

    cfg_s = '{ha:8, hf:2, hs:2, hb:2, va:4, vf:1, vs:1, vb:1, hp:1'b0, vp:1'b0};
    cfg_i = '{ha:8, hf:2, hs:2, hb:2, va:4, vf:1, vs:1, vb:1, hp:1'b1, vp:1'b1};
    cfg_d = '{ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33, hp:1'b0, vp:1'b0};

    // Cumulative from reset on the 14x7 raster: {cycles, pix_en, h, v, frame}.
    vecs[0] = '{cycles:0,   en:1'b1, h:0,  v:0, f:0};
    vecs[1] = '{cycles:13,  en:1'b1, h:13, v:0, f:0};
    vecs[2] = '{cycles:1,   en:1'b1, h:0,  v:1, f:0};
    vecs[3] = '{cycles:5,   en:1'b0, h:0,  v:1, f:0};
    vecs[4] = '{cycles:84,  en:1'b1, h:0,  v:0, f:1};
    vecs[5] = '{cycles:19,  en:1'b1, h:5,  v:1, f:1};
    vecs[6] = '{cycles:294, en:1'b1, h:5,  v:1, f:4};

    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_a_hsync", a_hs, 1);
    chk("rst_a_vsync", a_vs, 1);
    chk("rst_a_video_on", a_von, 1);
    chk("rst_b_hsync", b_hs, 0);
    chk("rst_b_vsync", b_vs, 0);
    chk("rst_a_frame", a_f, 0);
    rst = 1'b0;
    chk_on = 1'b1;

    foreach (vecs[i]) begin
      repeat (vecs[i].cycles) step(vecs[i].en);
      chk($sformatf("vec%0d_h", i), a_h, vecs[i].h);
      chk($sformatf("vec%0d_v", i), a_v, vecs[i].v);
      chk($sformatf("vec%0d_frame", i), a_f, vecs[i].f);
    end

    // One full frame with pix_en held high: count each decoded output.
    do_reset();
    von_n = 0; hs_n = 0; vs_n = 0; le_n = 0; fe_n = 0;
    pix_en = 1'b1;
    repeat (98) begin
      @(negedge clk);
      von_n += int'(a_von);
      hs_n  += int'(!a_hs);
      vs_n  += int'(!a_vs);
      le_n  += int'(a_le);
      fe_n  += int'(a_fe);
      @(posedge clk);
      #1;
    end
    chk("frame_video_on_clks", von_n, 32);
    chk("frame_hsync_low_clks", hs_n, 14);
    chk("frame_vsync_low_clks", vs_n, 14);
    chk("frame_line_ends", le_n, 7);
    chk("frame_frame_ends", fe_n, 1);
    chk("frame_count_after_98", a_f, 1);

    // Freeze at the terminal position, then release for exactly one tick.
    do_reset();
    repeat (97) step(1'b1);
    pix_en = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("freeze_h", a_h, 13);
      chk("freeze_v", a_v, 6);
      chk("freeze_line_end", a_le, 0);
      chk("freeze_frame_end", a_fe, 0);
      @(posedge clk);
      #1;
    end
    pix_en = 1'b1;
    @(negedge clk);
    chk("resume_line_end", a_le, 1);
    chk("resume_frame_end", a_fe, 1);
    @(posedge clk);
    #1;
    pix_en = 1'b0;
    chk("resume_wrap_h", a_h, 0);
    chk("resume_wrap_v", a_v, 0);
    chk("resume_frame", a_f, 1);
    @(negedge clk);
    chk("resume_line_end_drop", a_le, 0);

    // Asynchronous reset between edges at h=5, v=2.
    do_reset();
    repeat (33) step(1'b1);
    chk("pre_rst_h", a_h, 5);
    chk("pre_rst_v", a_v, 2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_h", a_h, 0);
    chk("async_v", a_v, 0);
    chk("async_video_on", a_von, 1);
    chk("async_a_hsync", a_hs, 1);
    chk("async_a_vsync", a_vs, 1);
    chk("async_b_hsync", b_hs, 0);
    chk("async_b_vsync", b_vs, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1);
    step(1'b1);
    chk("post_rst_h", a_h, 2);
    chk("post_rst_v", a_v, 0);

    // Random pix_en, covered by the every-cycle model comparison.
    repeat (4000) step($urandom_range(0, 3) != 0);

    // Default raster: two full lines inside a 7000-clk window.
    do_reset();
    le_n = 0; hs_n = 0;
    repeat (7000) begin
      @(negedge clk);
      le_n += int'(d_le);
      hs_n += int'(!d_hs);
    end
    chk("d_line_ends_7000clk", le_n, 2);
    chk("d_hsync_low_clks", hs_n, 768);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
